// File: rtl/seq_bit_serializer.sv
// seq_bit_serializer: parallel words in over valid/ready, shifted out one bit per clock with a one-word holding register
module seq_bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             xout,
  output logic             xout_valid,
  output logic             last_bit,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t           r_state;
  logic [WIDTH-1:0] r_sh, r_hold;
  logic [CW-1:0]    r_cnt;
  logic             r_hfull, r_xout, r_xv, r_last;
  logic [WIDTH-1:0] w_next;
  logic             w_load;
  function automatic logic head(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction
  assign din_ready  = !r_hfull && !reset;
  assign busy       = (r_state == SHIFT) || r_hfull;
  assign w_next     = MSB_FIRST ? r_sh << 1 : r_sh >> 1;
  // reload happens from IDLE or right after the last bit, giving gapless words
  assign w_load     = r_hfull && (r_state == IDLE || r_cnt == '0);
  assign xout       = r_xout;
  assign xout_valid = r_xv;
  assign last_bit   = r_last;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_sh    <= '0;
      r_hold  <= '0;
      r_cnt   <= '0;
      r_hfull <= 1'b0;
      r_xout  <= 1'b0;
      r_xv    <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      if (w_load) begin
        r_state <= SHIFT;
        r_sh    <= r_hold;
        r_cnt   <= CW'(WIDTH - 1);
        r_hfull <= 1'b0;
        r_xout  <= head(r_hold);
        r_xv    <= 1'b1;
        r_last  <= 1'b0;
      end else if (r_state == SHIFT && r_cnt != '0) begin
        r_sh    <= w_next;
        r_cnt   <= r_cnt - 1'b1;
        r_xout  <= head(w_next);
        r_last  <= (r_cnt == CW'(1));
      end else begin
        r_state <= IDLE;
        r_xout  <= 1'b0;
        r_xv    <= 1'b0;
        r_last  <= 1'b0;
      end
      if (din_valid && din_ready) begin
        r_hold  <= din;
        r_hfull <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_seq_bit_serializer.sv
// tb_seq_bit_serializer: random and directed stimulus on MSB-first and LSB-first instances against a word-schedule model
module tb_seq_bit_serializer;
  localparam int W = 8;
  logic         clk = 1'b0;
  logic         reset = 1'b1, din_valid = 1'b0;
  logic [W-1:0] din = '0;
  logic         m_rdy, m_x, m_xv, m_last, m_busy;
  logic         l_rdy, l_x, l_xv, l_last, l_busy;
  int           total = 0, bad = 0, e = 0;
  bit           acc;
  typedef struct {logic [W-1:0] w; int a; int s;} wd_t;
  wd_t q[$];
  always #5 clk = ~clk;
  seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(m_rdy),
    .xout(m_x), .xout_valid(m_xv), .last_bit(m_last), .busy(m_busy));
  seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(l_rdy),
    .xout(l_x), .xout_valid(l_xv), .last_bit(l_last), .busy(l_busy));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at edge %0d: got=%0h exp=%0h", tag, e, got, exp);
    end
  endtask
  // a word is held from its accept edge a until its transfer edge s; it is on xout after edges s..s+W-1
  function automatic bit hold_occ(input int x);
    foreach (q[i]) if (q[i].a <= x && x < q[i].s) return 1'b1;
    return 1'b0;
  endfunction
  function automatic int last_end();
    int r = -100;
    foreach (q[i]) if (q[i].s + W - 1 > r) r = q[i].s + W - 1;
    return r;
  endfunction
  task automatic step(input logic r, input logic v, input logic [W-1:0] d);
    bit rdy, ev, eb, lb;
    int idx;
    logic [W-1:0] ww;
    reset = r; din_valid = v; din = d;
    #1;
    rdy = !r && !hold_occ(e);
    chk("ready_msb", m_rdy, rdy);
    chk("ready_lsb", l_rdy, rdy);
    acc = rdy && v;
    @(posedge clk);
    e++;
    if (r) q.delete();
    else if (acc) q.push_back('{d, e, (e + 1 > last_end() + 1) ? e + 1 : last_end() + 1});
    #1;
    ev = 1'b0; idx = 0; ww = '0;
    foreach (q[i]) if (q[i].s <= e && e <= q[i].s + W - 1) begin ev = 1'b1; idx = e - q[i].s; ww = q[i].w; end
    eb = ev && ww[W-1-idx];
    lb = ev && ww[idx];
    chk("xv_msb", m_xv, ev);
    chk("xv_lsb", l_xv, ev);
    chk("x_msb", m_x, eb);
    chk("x_lsb", l_x, lb);
    chk("last_msb", m_last, ev && idx == W - 1);
    chk("last_lsb", l_last, ev && idx == W - 1);
    chk("busy_msb", m_busy, ev || hold_occ(e));
    chk("busy_lsb", l_busy, ev || hold_occ(e));
    while (q.size() > 0 && q[0].s + W < e) void'(q.pop_front());
  endtask
  task automatic send(input logic [W-1:0] d);
    int n = 0;
    do begin step(1'b0, 1'b1, d); n++; end while (!acc && n < 60);
    if (!acc) chk("send_timeout", 32'(n), 32'(0));
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
  endtask
  initial begin
    logic v;
    logic [W-1:0] d;
    step(1'b1, 1'b1, 8'hFF);
    step(1'b1, 1'b1, 8'hFF);
    idle(4);
    send(8'hE7);
    idle(12);
    send(8'hFF); send(8'h00); send(8'hA5);
    idle(30);
    send(8'h01);
    idle(12);
    send(8'hFF); send(8'hAA); send(8'h3C);
    idle(30);
    send(8'hF0);
    idle(1);
    send(8'h81);
    idle(1);
    step(1'b1, 1'b0, '0);
    idle(3);
    send(8'h81);
    idle(12);
    v = 1'b0; d = '0;
    for (int k = 0; k < 3000; k++) begin
      if (!(v && !acc)) begin
        v = $urandom_range(0, 2) != 0;
        d = W'($urandom);
      end
      step($urandom_range(0, 79) == 0, v, d);
    end
    idle(20);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seq_bit_serializer.md
Name: seq_bit_serializer

Overview:
Upstream feeder for the serial sequence detectors. Accepts parallel words over a valid/ready handshake and shifts them out one bit per clock on a serial output, which drives the detector's xin input. A one-word holding register lets back-to-back words stream with no idle bit between them. While idle, the serial output is driven 0, so the downstream detector sees no spurious 1s.

Parameters:
WIDTH, 8, word width in bits; legal range WIDTH >= 2.
MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
din  input  WIDTH  parallel word; must be stable while din_valid=1 and din_ready=0
din_valid  input  1  upstream has a word on din
din_ready  output  1  holding register can accept a word
xout  output  1  serial bit, registered; drives detector xin
xout_valid  output  1  xout carries a data bit this cycle, registered
last_bit  output  1  xout is the final bit of the current word, registered
busy  output  1  shifter active or holding register full

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high.
- Reset (sampled at a clk edge with reset=1):
  - state=IDLE; shift register, bit counter and holding register cleared; hold_full=0.
  - Outputs: xout=0, xout_valid=0, last_bit=0, busy=0.
  - din_ready is forced 0 while reset=1; no handshake completes while reset is high.
- Handshake:
  - din_ready = !hold_full && !reset (combinational).
  - A word is accepted at an edge where din_valid && din_ready; it is written to the holding register and hold_full is set.
  - din_valid may assert and deassert freely; nothing is captured without din_ready.
- FSM states: IDLE and SHIFT.
  - IDLE -> SHIFT: at the edge where hold_full=1. The holding word loads into the shifter, the bit counter is set to WIDTH-1, and hold_full clears.
  - SHIFT, counter > 0: at each edge, shift one position toward the output end and decrement the counter.
  - SHIFT, counter == 0 (last bit presented): if hold_full=1, reload from the holding register and stay in SHIFT (gapless); otherwise go to IDLE.
  - Accept and transfer on the same edge: the transfer empties the holding register at that edge. Because din_ready was 0 that cycle, an accept and a transfer never collide on the holding register.
- Output timing (all registered from the shifter):
  - Accept at edge N with shifter idle -> transfer at edge N+1 -> the first bit appears on xout in the cycle after edge N+1.
  - xout_valid is high for exactly WIDTH consecutive cycles per word.
  - last_bit is high only in the final bit cycle.
  - Latency, accept edge to first valid bit: 2 edges.
- Streaming: if the next word is accepted before the current word's last bit, xout_valid stays continuously high across the word boundary. Throughput is 1 word per WIDTH cycles.
- Idle output: when xout_valid=0, xout=0 and last_bit=0.
- Bit order:
  - MSB_FIRST=1: order is din[WIDTH-1] down to din[0].
  - MSB_FIRST=0: order is din[0] up to din[WIDTH-1].
- busy = (state==SHIFT) || hold_full.
- Counter width: $clog2(WIDTH) bits. It never wraps below 0; reaching 0 forces either a reload or IDLE.
- Reset mid-word: the partial word and any held word are discarded. xout, xout_valid and last_bit are 0 in the cycle after the reset edge. The next accepted word starts from its first bit.

Test Plan:
- Reset: reset=1 for 2 cycles with din_valid=1, din=8'hFF -> din_ready=0, xout=0, xout_valid=0; after reset drops nothing is emitted until a new accept.
- Single word (WIDTH=8, MSB_FIRST=1), din=8'hE7 accepted at edge N -> cycles N+1..N+8 show xout = 1,1,1,0,0,1,1,1 with xout_valid=1; last_bit=1 only in the 8th cycle; xout=0 and xout_valid=0 afterwards.
- Back-to-back 8'hFF, 8'h00, 8'hA5 with din_valid held high -> xout_valid high for 24 consecutive cycles; bit stream FF|00|A5 MSB-first; din_ready low whenever hold_full=1.
- Backpressure: hold 8'h3C on din with din_valid=1 while the shifter is mid-word and hold_full=1 -> din_ready=0 and the word is not captured; when din_ready rises, 8'h3C is captured exactly once and emitted intact.
- MSB_FIRST=0, din=8'h01 -> xout = 1,0,0,0,0,0,0,0; last_bit on the 8th bit.
- Reset after 3 bits of 8'hF0, with 8'h81 held -> after the reset edge xout=0 and xout_valid=0; hold is cleared; a fresh accept of 8'h81 emits 1,0,0,0,0,0,0,1.
